// File: rtl/ddr_round_sequencer.sv
// Dance-game round sequencer: streams the song chart into a 10-slot arrow
// window, judges presses against the bottom slot, tracks score and lives.
module ddr_round_sequencer #(
    parameter int DATA_W        = 10,
    parameter int ADDR_W        = 10,
    parameter int SCORE_W       = 14,
    parameter int LIVES         = 3,
    parameter int STRAY_PENALTY = 1
) (
    input  logic               onehz_clk,
    input  logic               rst,
    input  logic               start,
    input  logic               hit_valid,
    input  logic [2:0]         hit_dir,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [DATA_W-1:0]  mem_data,
    output logic [29:0]        arrows,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         lives,
    output logic [1:0]         game_state,
    output logic               pressed,
    output logic               miss
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        OVER = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam logic [2:0]  BLANK      = 3'b100;
    localparam logic [29:0] CLEAR      = {10{BLANK}};
    localparam logic [2:0]  LIVES_INIT = 3'(LIVES);

    state_t             state, state_n;
    logic [29:0]        arr_q, arr_n;
    logic [SCORE_W-1:0] score_q, score_n;
    logic [2:0]         lives_q, lives_n;
    logic               pressed_n, miss_n;
    // One extra bit so ptr can step past a full 1023-entry song
    logic [ADDR_W:0]    ptr_q, ptr_n;
    logic [ADDR_W-1:0]  len_q, len_n;

    logic [2:0] target;
    logic [2:0] note;
    logic       is_hit;
    logic       is_lose;
    logic       fed;

    assign target = arr_q[2:0];
    assign note   = mem_data[2] ? BLANK : mem_data[2:0];

    always_comb begin
        state_n   = state;
        arr_n     = arr_q;
        score_n   = score_q;
        lives_n   = lives_q;
        ptr_n     = ptr_q;
        len_n     = len_q;
        pressed_n = 1'b0;
        miss_n    = 1'b0;
        is_hit    = 1'b0;
        is_lose   = 1'b0;
        fed       = 1'b0;
        unique case (state)
            IDLE: begin
                arr_n = CLEAR;
                if (start) begin
                    len_n   = ADDR_W'(mem_data);
                    ptr_n   = (ADDR_W+1)'(1);
                    score_n = '0;
                    lives_n = LIVES_INIT;
                    state_n = PLAY;
                end
            end
            PLAY: begin
                is_hit  = (target != BLANK) && hit_valid
                          && (hit_dir == target);
                is_lose = ((target != BLANK) && !is_hit)
                          || ((target == BLANK) && hit_valid
                              && (STRAY_PENALTY != 0));
                if (is_hit) begin
                    pressed_n = 1'b1;
                    if (score_q != '1)
                        score_n = score_q + 1'b1;
                end
                if (is_lose) begin
                    miss_n  = 1'b1;
                    lives_n = lives_q - 3'd1;
                end
                fed   = ptr_q <= {1'b0, len_q};
                arr_n = {fed ? note : BLANK, arr_q[29:3]};
                if (fed)
                    ptr_n = ptr_q + 1'b1;
                if (is_lose && lives_q == 3'd1)
                    state_n = OVER;
                else if (ptr_n > {1'b0, len_q} && arr_n == CLEAR)
                    state_n = DONE;
            end
            OVER, DONE: begin
                if (start) begin
                    state_n = IDLE;
                    arr_n   = CLEAR;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge onehz_clk) begin
        if (rst) begin
            state   <= IDLE;
            arr_q   <= CLEAR;
            score_q <= '0;
            lives_q <= LIVES_INIT;
            ptr_q   <= (ADDR_W+1)'(1);
            len_q   <= '0;
            pressed <= 1'b0;
            miss    <= 1'b0;
        end else begin
            state   <= state_n;
            arr_q   <= arr_n;
            score_q <= score_n;
            lives_q <= lives_n;
            ptr_q   <= ptr_n;
            len_q   <= len_n;
            pressed <= pressed_n;
            miss    <= miss_n;
        end
    end

    assign mem_addr   = (state == PLAY) ? ptr_q[ADDR_W-1:0] : '0;
    assign arrows     = arr_q;
    assign score      = score_q;
    assign lives      = lives_q;
    assign game_state = state;

endmodule

// File: tb/tb_ddr_round_sequencer.sv
// Bench for ddr_round_sequencer: two instances (default and 2-bit score with
// stray presses ignored) driven together from a table of tick records.
module tb_ddr_round_sequencer;

    typedef struct {
        int          rom;
        logic        r;
        logic        s;
        logic        hv;
        logic [2:0]  hd;
        int          n;
        logic [1:0]  st;
        logic [13:0] sc;
        logic [2:0]  lv;
        logic        p;
        logic        m;
        logic [1:0]  sc1;
        logic [2:0]  lv1;
        logic        p1;
        logic        m1;
        logic        ca;
        logic [29:0] arr;
        logic [9:0]  addr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        hit_valid = 1'b0;
    logic [2:0]  hit_dir = 3'b000;
    logic [9:0]  a0, a1;
    logic [9:0]  d0, d1;
    logic [29:0] arr0, arr1;
    logic [13:0] score0;
    logic [1:0]  score1;
    logic [2:0]  lives0, lives1;
    logic [1:0]  st0, st1;
    logic        p0, p1, m0, m1;
    logic [9:0]  rom [1024];

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    assign d0 = rom[a0];
    assign d1 = rom[a1];

    ddr_round_sequencer dut0 (
        .onehz_clk(clk), .rst(rst), .start(start),
        .hit_valid(hit_valid), .hit_dir(hit_dir),
        .mem_addr(a0), .mem_data(d0), .arrows(arr0),
        .score(score0), .lives(lives0), .game_state(st0),
        .pressed(p0), .miss(m0)
    );

    ddr_round_sequencer #(.SCORE_W(2), .STRAY_PENALTY(0)) dut1 (
        .onehz_clk(clk), .rst(rst), .start(start),
        .hit_valid(hit_valid), .hit_dir(hit_dir),
        .mem_addr(a1), .mem_data(d1), .arrows(arr1),
        .score(score1), .lives(lives1), .game_state(st1),
        .pressed(p1), .miss(m1)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load_rom(input int sel);
        for (int i = 0; i < 1024; i++) rom[i] = 10'd0;
        case (sel)
            0: begin
                rom[0] = 10'd3; rom[1] = 10'd0;
                rom[2] = 10'd1; rom[3] = 10'd2;
            end
            1: begin
                rom[0] = 10'd5;
                for (int i = 1; i <= 5; i++) rom[i] = 10'd0;
            end
            2: begin
                rom[0] = 10'd2; rom[1] = 10'h3ff; rom[2] = 10'd0;
            end
            default: rom[0] = 10'd0;
        endcase
    endtask

    function automatic vec_t mk(
        int rom_sel, logic r, logic s, logic hv, logic [2:0] hd, int n,
        logic [1:0] st, logic [13:0] sc, logic [2:0] lv, logic p, logic m,
        logic [1:0] sc1, logic [2:0] lv1, logic p1x, logic m1x,
        logic ca, logic [29:0] arr, logic [9:0] addr);
        vec_t v;
        v.rom = rom_sel; v.r = r; v.s = s; v.hv = hv; v.hd = hd; v.n = n;
        v.st = st; v.sc = sc; v.lv = lv; v.p = p; v.m = m;
        v.sc1 = sc1; v.lv1 = lv1; v.p1 = p1x; v.m1 = m1x;
        v.ca = ca; v.arr = arr; v.addr = addr;
        return v;
    endfunction

    initial begin
        logic [29:0] bl, w1, w3, w10, c10;
        vec_t e;
        bl  = {10{3'b100}};
        w1  = {3'b000, {9{3'b100}}};
        w3  = {3'b010, 3'b001, 3'b000, {7{3'b100}}};
        w10 = {{7{3'b100}}, 3'b010, 3'b001, 3'b000};
        c10 = {{5{3'b100}}, {5{3'b000}}};

        // reset
        tbl.push_back(mk(0,1,0,0,0,2, 0,0,3,0,0, 0,3,0,0, 1,bl,0));
        // all notes hit
        tbl.push_back(mk(-1,0,1,0,0,1, 1,0,3,0,0, 0,3,0,0, 1,bl,1));
        tbl.push_back(mk(-1,0,0,0,0,1, 1,0,3,0,0, 0,3,0,0, 1,w1,2));
        tbl.push_back(mk(-1,0,0,0,0,2, 1,0,3,0,0, 0,3,0,0, 1,w3,4));
        tbl.push_back(mk(-1,0,0,0,0,7, 1,0,3,0,0, 0,3,0,0, 1,w10,4));
        tbl.push_back(mk(-1,0,0,1,0,1, 1,1,3,1,0, 1,3,1,0, 0,bl,0));
        tbl.push_back(mk(-1,0,0,1,1,1, 1,2,3,1,0, 2,3,1,0, 0,bl,0));
        tbl.push_back(mk(-1,0,0,1,2,1, 3,3,3,1,0, 3,3,1,0, 1,bl,0));
        tbl.push_back(mk(-1,0,0,0,0,1, 3,3,3,0,0, 3,3,0,0, 1,bl,0));
        tbl.push_back(mk(-1,0,1,0,0,1, 0,3,3,0,0, 3,3,0,0, 1,bl,0));
        // no presses, start held into PLAY
        tbl.push_back(mk(-1,0,1,0,0,1, 1,0,3,0,0, 0,3,0,0, 1,bl,1));
        tbl.push_back(mk(-1,0,1,0,0,1, 1,0,3,0,0, 0,3,0,0, 1,w1,2));
        tbl.push_back(mk(-1,0,0,0,0,9, 1,0,3,0,0, 0,3,0,0, 1,w10,4));
        tbl.push_back(mk(-1,0,0,0,0,1, 1,0,2,0,1, 0,2,0,1, 0,bl,0));
        tbl.push_back(mk(-1,0,0,0,0,1, 1,0,1,0,1, 0,1,0,1, 0,bl,0));
        tbl.push_back(mk(-1,0,0,0,0,1, 2,0,0,0,1, 0,0,0,1, 1,bl,0));
        tbl.push_back(mk(-1,0,0,1,0,3, 2,0,0,0,0, 0,0,0,0, 1,bl,0));
        // stray press + score saturation on dut1
        tbl.push_back(mk(1,0,1,0,0,1, 0,0,0,0,0, 0,0,0,0, 1,bl,0));
        tbl.push_back(mk(-1,0,1,0,0,1, 1,0,3,0,0, 0,3,0,0, 1,bl,1));
        tbl.push_back(mk(-1,0,0,0,0,4, 1,0,3,0,0, 0,3,0,0, 0,bl,0));
        tbl.push_back(mk(-1,0,0,1,0,1, 1,0,2,0,1, 0,3,0,0, 0,bl,0));
        tbl.push_back(mk(-1,0,0,0,0,5, 1,0,2,0,0, 0,3,0,0, 1,c10,6));
        tbl.push_back(mk(-1,0,0,1,0,4, 1,4,2,1,0, 3,3,1,0, 0,bl,0));
        tbl.push_back(mk(-1,0,0,1,0,1, 3,5,2,1,0, 3,3,1,0, 1,bl,0));
        // wrong direction, then mid-round reset
        tbl.push_back(mk(0,0,1,0,0,1, 0,5,2,0,0, 3,3,0,0, 1,bl,0));
        tbl.push_back(mk(-1,0,1,0,0,1, 1,0,3,0,0, 0,3,0,0, 1,bl,1));
        tbl.push_back(mk(-1,0,0,0,0,10, 1,0,3,0,0, 0,3,0,0, 1,w10,4));
        tbl.push_back(mk(-1,0,0,1,3,1, 1,0,2,0,1, 0,2,0,1, 0,bl,0));
        tbl.push_back(mk(-1,0,0,1,1,1, 1,1,2,1,0, 1,2,1,0, 0,bl,0));
        tbl.push_back(mk(-1,1,0,0,0,1, 0,0,3,0,0, 0,3,0,0, 1,bl,0));
        // sanitised ROM codes
        tbl.push_back(mk(2,0,1,0,0,1, 1,0,3,0,0, 0,3,0,0, 1,bl,1));
        tbl.push_back(mk(-1,0,0,0,0,1, 1,0,3,0,0, 0,3,0,0, 1,bl,2));
        tbl.push_back(mk(-1,0,0,0,0,1, 1,0,3,0,0, 0,3,0,0, 1,w1,3));
        tbl.push_back(mk(-1,1,0,0,0,1, 0,0,3,0,0, 0,3,0,0, 1,bl,0));
        // empty song
        tbl.push_back(mk(3,0,1,0,0,1, 1,0,3,0,0, 0,3,0,0, 1,bl,1));
        tbl.push_back(mk(-1,0,0,0,0,1, 3,0,3,0,0, 0,3,0,0, 1,bl,0));

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rom >= 0) load_rom(tbl[i].rom);
            rst       = tbl[i].r;
            start     = tbl[i].s;
            hit_valid = tbl[i].hv;
            hit_dir   = tbl[i].hd;
            sb.push_back(tbl[i]);
            repeat (tbl[i].n) @(posedge clk);
            #1;
            e = sb.pop_front();
            chk($sformatf("r%0d state", i), 32'(st0), 32'(e.st));
            chk($sformatf("r%0d score", i), 32'(score0), 32'(e.sc));
            chk($sformatf("r%0d lives", i), 32'(lives0), 32'(e.lv));
            chk($sformatf("r%0d pressed", i), 32'(p0), 32'(e.p));
            chk($sformatf("r%0d miss", i), 32'(m0), 32'(e.m));
            chk($sformatf("r%0d state1", i), 32'(st1), 32'(e.st));
            chk($sformatf("r%0d score1", i), 32'(score1), 32'(e.sc1));
            chk($sformatf("r%0d lives1", i), 32'(lives1), 32'(e.lv1));
            chk($sformatf("r%0d pressed1", i), 32'(p1), 32'(e.p1));
            chk($sformatf("r%0d miss1", i), 32'(m1), 32'(e.m1));
            if (e.ca) begin
                chk($sformatf("r%0d arrows", i), 32'(arr0), 32'(e.arr));
                chk($sformatf("r%0d addr", i), 32'(a0), 32'(e.addr));
                chk($sformatf("r%0d arrows1", i), 32'(arr1), 32'(e.arr));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
